pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: picks one action class per cycle (data-memory
// stall, branch flush, load-use stall, fetch stall or run), drives the pipeline
// register enables/flushes combinationally from it, and keeps a registered copy
// of the class, stall/flush performance counters and a sticky data-memory
// timeout flag.
//
// Handshake note: dmem_req/dmem_ready and imem_ready are level qualifiers, not
// valid/ready pairs. A MEM access is outstanding while dmem_req=1 and finishes
// in the cycle where dmem_ready=1. A fetch is usable only in a cycle where
// imem_ready=1. Nothing here ever waits on an output of this block.
module pipeline_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_r,
  output logic             id_ex_en,
  output logic             id_ex_r,
  output logic             back_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dmem_err
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DSTALL  = 3'd1,
    BRFLUSH = 3'd2,
    LUSTALL = 3'd3,
    ISTALL  = 3'd4
  } cls_t;

  // Wait counter only needs to reach TIMEOUT, where it saturates.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  cls_t              cls;
  cls_t              state_q;
  logic              load_use;
  logic [WAIT_W-1:0] wait_cnt;

  // Writes to x0 are discarded, so a load to x0 can never create a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // Pick the highest-priority action class and drive the pipeline controls.
  // A branch seen during a data stall is simply outranked; it takes effect in
  // the first cycle the memory completes if EX still holds it.
  always_comb begin
    cls      = RUN;
    pc_en    = 1'b1;
    if_id_en = 1'b1;
    if_id_r  = 1'b0;
    id_ex_en = 1'b1;
    id_ex_r  = 1'b0;
    back_en  = 1'b1;
    if (dmem_req && !dmem_ready) begin
      cls      = DSTALL;
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      back_en  = 1'b0;
    end else if (ex_branch_taken) begin
      cls     = BRFLUSH;
      if_id_r = 1'b1;
      id_ex_r = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push a bubble into EX (flush needs its enable high).
      cls      = LUSTALL;
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_r  = 1'b1;
    end else if (!imem_ready) begin
      // Hold PC, turn the stale fetch into a bubble, let the rest drain.
      cls     = ISTALL;
      pc_en   = 1'b0;
      if_id_r = 1'b1;
    end
  end

  // Record the class, count stalls/flushes and track data-memory wait time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      dmem_err  <= 1'b0;
    end else begin
      state_q <= cls;
      if (cls == DSTALL || cls == LUSTALL || cls == ISTALL) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (cls == BRFLUSH) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (cls == DSTALL) begin
        if (wait_cnt == WAIT_MAX) begin
          dmem_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios followed by random
// traffic, checked against a priority-rule reference model.
module tb_pipeline_ctrl;

  localparam int TMO  = 4;
  localparam int CW   = 8;
  localparam int MASK = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic          imem_ready, dmem_req, dmem_ready;
  logic          pc_en, if_id_en, if_id_r, id_ex_en, id_ex_r, back_en;
  logic [2:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          dmem_err;
  logic [5:0]    ctl_vec;

  pipeline_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_r(if_id_r),
    .id_ex_en(id_ex_en), .id_ex_r(id_ex_r), .back_en(back_en),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dmem_err(dmem_err)
  );

  assign ctl_vec = {pc_en, if_id_en, if_id_r, id_ex_en, id_ex_r, back_en};

  // ---------------- reference model ----------------
  // Expected {pc_en, if_id_en, if_id_r, id_ex_en, id_ex_r, back_en} per class.
  logic [5:0] ctl_tab [5];
  int n_assert = 0;
  int n_fail   = 0;
  int m_state, m_stall, m_flush, m_consec;
  bit m_err;

  function automatic int model_class();
    int srcs[$];
    bit hazard = 0;
    if (id_use_rs1) srcs.push_back(int'(id_rs1));
    if (id_use_rs2) srcs.push_back(int'(id_rs2));
    if (ex_mem_read && ex_rd != 0)
      foreach (srcs[i]) if (srcs[i] == int'(ex_rd)) hazard = 1;
    if (dmem_req && !dmem_ready) return 1;
    if (ex_branch_taken)         return 2;
    if (hazard)                  return 3;
    if (!imem_ready)             return 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_flush = 0; m_consec = 0; m_err = 0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_state"}, 64'(state), 64'(m_state));
    chk({tag, "_stall"}, 64'(stall_cnt), 64'(m_stall));
    chk({tag, "_flush"}, 64'(flush_cnt), 64'(m_flush));
    chk({tag, "_err"},   64'(dmem_err), 64'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    int c;
    #3;
    c = model_class();
    chk({tag, "_ctl"}, 64'(ctl_vec), 64'(ctl_tab[c]));
    chk({tag, "_flush_needs_en"},
        64'({(if_id_r & ~if_id_en), (id_ex_r & ~id_ex_en)}), 64'(0));
    @(posedge clk);
    #1;
    if (!rst) begin
      m_state = c;
      if (c == 1 || c == 3 || c == 4) m_stall = (m_stall + 1) & MASK;
      if (c == 2) m_flush = (m_flush + 1) & MASK;
      if (c == 1) begin
        if (m_consec >= TMO) m_err = 1;
        m_consec++;
      end else begin
        m_consec = 0;
      end
    end
    chk_regs(tag);
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk_regs("rst_now");
    cycle("rst_hold");
    rst = 1'b0;
  endtask

  int burst;

  // ---------------- stimulus ----------------
  initial begin
    ctl_tab[0] = 6'b110101;
    ctl_tab[1] = 6'b000000;
    ctl_tab[2] = 6'b111111;
    ctl_tab[3] = 6'b000111;
    ctl_tab[4] = 6'b011101;
    set_idle();
    do_reset();

    // Load x5 then use x5: one stall, then run.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
    cycle("lu");
    chk("lu_state", 64'(state), 64'd3);
    set_idle();
    cycle("lu_after");
    chk("lu_run", 64'(state), 64'd0);
    chk("lu_cnt", 64'(stall_cnt), 64'd1);

    // Branch outranks load-use.
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_use_rs2 = 1'b1; id_rs2 = 5'd7;
    ex_branch_taken = 1'b1;
    cycle("br_lu");
    chk("br_lu_ctl", 64'(ctl_vec), 64'b111111);
    chk("br_lu_flush", 64'(flush_cnt), 64'd1);
    chk("br_lu_stall", 64'(stall_cnt), 64'd0);
    set_idle();

    // Branch deferred behind a 3-cycle data stall.
    do_reset();
    ex_branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("defer_stall");
    dmem_ready = 1'b1;
    cycle("defer_br");
    chk("defer_stall_cnt", 64'(stall_cnt), 64'd3);
    chk("defer_flush_cnt", 64'(flush_cnt), 64'd1);
    set_idle();

    // Two fetch stalls.
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle("istall");
      chk("istall_state", 64'(state), 64'd4);
    end
    set_idle();
    cycle("istall_end");

    // Load to x0 never stalls.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    cycle("x0");
    chk("x0_state", 64'(state), 64'd0);
    set_idle();

    // Timeout: error after the 5th stalled edge, cleared by async reset.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cycle("tmo");
      chk("tmo_err_edge", 64'(dmem_err), (i >= 5) ? 64'd1 : 64'd0);
    end
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_err", 64'(dmem_err), 64'd0);
    chk("async_state", 64'(state), 64'd0);
    chk("async_stall", 64'(stall_cnt), 64'd0);
    cycle("rst_hold_stall");
    rst = 1'b0;
    set_idle();

    // Stall counter wraps modulo 2^CW.
    imem_ready = 1'b0;
    for (int i = 0; i < 260; i++) cycle("wrap");
    chk("wrap_cnt", 64'(stall_cnt), 64'd4);
    set_idle();

    // Random traffic with occasional long memory waits.
    do_reset();
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        set_idle();
        do_reset();
      end
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 7);
      dmem_req = (burst > 0) || ($urandom_range(0, 2) == 0);
      dmem_ready = (burst == 0);
      if (burst > 0) burst--;
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
